pulse_stretcher: RTL and testbench
==================================

# pulse_stretcher

Converts a one-cycle tick (as produced by the team's edge detector on a debounced button) into a level output of programmable duration. It is the output half of the timer switch: tick in, lamp/relay enable out. Duration is counted in prescaled time units, with optional retriggering, an abort input and a post-expiry hold-off window. It sits between the tick source and the output driver.

## Interface

- DIV, 50: clock cycles per time unit; legal range DIV ≥ 1.
- W, 8: width of `duration` and `remaining`.
- HOLDOFF, 4: cycles after expiry or cancel during which `trig` is ignored; 0 means no hold-off.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- trig  in  1  start request; one-cycle tick, sampled every clock.
- cancel  in  1  abort of an active period.
- retrig  in  1  when 1, `trig` during ACTIVE reloads the period.
- duration  in  W  period length in time units, sampled when a trigger is accepted.
- out  out  1  registered level; high during the active period.
- busy  out  1  high in ACTIVE and HOLDOFF.
- done  out  1  one-cycle pulse on natural expiry only.
- remaining  out  W  time units left; 0 when not ACTIVE.

## Operation

- States: IDLE, ACTIVE, HOLDOFF.
- Counters:
  - prescaler `pre`: width clog2(DIV), minimum 1 bit, counts 0..DIV-1.
  - unit counter `remaining`: W bits.
  - hold-off counter: wide enough for HOLDOFF.
- Reset values: state=IDLE, out=0, busy=0, done=0, remaining=0, pre=0, hold-off counter=0.

IDLE
- trig=1, cancel=0, duration≠0: load remaining=duration and pre=0, go to ACTIVE.
- trig with duration=0 is ignored.
- cancel=1 in the same cycle as trig: cancel wins and nothing starts.

ACTIVE
- Priority: cancel > retrigger > count.
- cancel=1: go to HOLDOFF with remaining=0. No done pulse.
- trig=1 with retrig=1 and duration≠0: reload remaining=duration and pre=0. This replaces any decrement that would have happened in the same cycle.
- trig=1 with retrig=0, or with duration=0: ignored.
- Otherwise `pre` increments. When pre=DIV-1:
  - pre wraps to 0 and remaining decrements.
  - If remaining was 1, the period expires: go to HOLDOFF and pulse done.
- No wrap-around: remaining never decrements below 0.

HOLDOFF
- Load the hold-off counter with HOLDOFF on entry.
- trig and cancel are ignored.
- Return to IDLE after HOLDOFF cycles.
- If HOLDOFF=0, expiry and cancel go directly to IDLE; done still pulses on expiry.

Outputs
- out=1 exactly while state=ACTIVE.
- busy=1 while state≠IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

Reset
- rst asserted mid-period clears everything immediately (asynchronous) with no done pulse.

## Timing

- Trigger accepted on clock edge t: out=1 from the cycle after t for exactly duration×DIV cycles.
- Naming those cycles c1..cN with N = duration×DIV, out falls at cycle N+1, and done=1 in that same cycle for 1 cycle.
- busy stays high through cycle N+HOLDOFF.
- A trig sampled at the edge ending cycle N+HOLDOFF+1 or later is accepted.
- Retrigger accepted on edge t': the period restarts; out stays high continuously for duration×DIV cycles after t'.
- Cancel sampled at edge t: out=0 and remaining=0 from the next cycle; done stays 0.
- The value shown in `remaining` reflects the state after each edge.

## Test plan

All tests use DIV=4, W=8, HOLDOFF=3.

1. Reset and basic period:
   - Stimulus: rst pulse, then trig with duration=3.
   - Required response: all outputs 0 during and after reset; out high for exactly 12 cycles; done high for 1 cycle at the first low cycle; remaining steps 3→2→1→0 every 4 cycles; busy high for 15 cycles.
2. Zero duration and cancel-over-trig:
   - Stimulus: trig with duration=0; then trig and cancel together in IDLE.
   - Required response: out, busy and done stay 0 in both cases.
3. Retrigger:
   - Stimulus: retrig=1, duration=2, trig; second trig on the 6th high cycle.
   - Required response: out high for 5+8=13 consecutive cycles; exactly one done.
   - Stimulus: repeat with retrig=0.
   - Required response: second trig ignored; out high for 8 cycles.
4. Cancel mid-period:
   - Stimulus: duration=5, cancel on the 7th high cycle.
   - Required response: out falls the next cycle; remaining=0; done never asserts; busy high for 3 more cycles.
5. Hold-off boundary:
   - Stimulus: trig on each of the 3 hold-off cycles, then trig on the first IDLE cycle.
   - Required response: the first three are ignored; the last starts a new period.
6. Async reset mid-operation and DIV=1:
   - Stimulus: assert rst mid-ACTIVE, between clock edges.
   - Required response: out and busy drop immediately; no done.
   - Stimulus: DIV=1, duration=1.
   - Required response: out high for exactly 1 cycle, with done in the following cycle.

Source files
------------

// File: rtl/pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module   : pulse_stretcher
// Purpose  : Turns a one-cycle tick into a level of programmable duration,
//            counted in prescaled time units, with retrigger, cancel and a
//            post-period hold-off window during which new ticks are ignored.
// Revision : 1.0  initial release
// ============================================================================
module pulse_stretcher #(
  parameter int DIV     = 50,
  parameter int W       = 8,
  parameter int HOLDOFF = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         trig,
  input  logic         cancel,
  input  logic         retrig,
  input  logic [W-1:0] duration,
  output logic         out,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] remaining
);

  // Prescaler needs at least one bit even when DIV is 1.
  localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
  // Hold-off counter must be able to hold the value HOLDOFF itself.
  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic [PRE_W-1:0]    pre_q,       pre_d;
  logic [W-1:0]        remaining_q, remaining_d;
  logic [HOLD_W-1:0]   hold_q,      hold_d;
  logic                out_q,       out_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                period_end;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d     = state_q;
    pre_d       = pre_q;
    remaining_d = remaining_q;
    hold_d      = hold_q;
    done_d      = 1'b0;
    period_end  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Cancel beats a simultaneous trigger; a zero duration never starts.
        if (trig && !cancel && (duration != '0)) begin
          state_d     = ST_ACTIVE;
          remaining_d = duration;
          pre_d       = '0;
        end
      end

      ST_ACTIVE: begin
        if (cancel) begin
          remaining_d = '0;
          pre_d       = '0;
          period_end  = 1'b1;
        end else if (trig && retrig && (duration != '0)) begin
          // Reload replaces any decrement that would have happened now.
          remaining_d = duration;
          pre_d       = '0;
        end else if (pre_q == PRE_MAX) begin
          pre_d = '0;
          if (remaining_q <= W'(1)) begin
            remaining_d = '0;
            done_d      = 1'b1;
            period_end  = 1'b1;
          end else begin
            remaining_d = remaining_q - W'(1);
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end

      ST_HOLDOFF: begin
        // trig and cancel are deliberately ignored here.
        if (hold_q <= HOLD_W'(1)) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end

      default: begin
        state_d     = ST_IDLE;
        pre_d       = '0;
        remaining_d = '0;
        hold_d      = '0;
      end
    endcase

    // Expiry and cancel share the exit path; without hold-off go straight idle.
    if (period_end) begin
      if (HOLDOFF == 0) begin
        state_d = ST_IDLE;
        hold_d  = '0;
      end else begin
        state_d = ST_HOLDOFF;
        hold_d  = HOLD_LOAD;
      end
    end

    out_d  = (state_d == ST_ACTIVE);
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pre_q       <= '0;
      remaining_q <= '0;
      hold_q      <= '0;
      out_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      remaining_q <= remaining_d;
      hold_q      <= hold_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out       = out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = remaining_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_stretcher
// Purpose  : Self-checking bench for pulse_stretcher (DIV=4, W=8, HOLDOFF=3,
//            plus a DIV=1 instance). Expected per-cycle outputs are queued
//            when stimulus is applied and popped as each cycle is sampled.
// Revision : 1.0  initial release
// ============================================================================
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       trig;
  logic       cancel;
  logic       retrig;
  logic [7:0] duration;

  logic       out,  busy,  done;
  logic [7:0] remaining;
  logic       out1, busy1, done1;
  logic [7:0] remaining1;

  int n_vec = 0;
  int n_err = 0;

  // Expected {out, busy, done, remaining}, one entry per sampled cycle.
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  pulse_stretcher #(.DIV(4), .W(8), .HOLDOFF(3)) u_dut (
    .clk(clk), .rst(rst), .trig(trig), .cancel(cancel), .retrig(retrig),
    .duration(duration), .out(out), .busy(busy), .done(done),
    .remaining(remaining)
  );

  pulse_stretcher #(.DIV(1), .W(8), .HOLDOFF(3)) u_dut1 (
    .clk(clk), .rst(rst), .trig(trig), .cancel(cancel), .retrig(retrig),
    .duration(duration), .out(out1), .busy(busy1), .done(done1),
    .remaining(remaining1)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] got, ex;
    for (int i = 0; i < 6; i++) exp_q.push_back(11'd0);
    rst = 1'b1;
    #1;
    got = {out, busy, done, remaining}; ex = exp_q.pop_front(); n_vec++;
    if (got !== ex) begin
      n_err++;
      $display("FAIL reset_async: got %b/%b/%b/%0d want %b/%b/%b/%0d",
               got[10], got[9], got[8], got[7:0], ex[10], ex[9], ex[8], ex[7:0]);
    end
    // A trigger while reset is held must not start anything.
    trig = 1'b1; duration = 8'd3;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 3) begin rst = 1'b0; trig = 1'b0; end
      got = {out, busy, done, remaining}; ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL reset c%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", k,
                 got[10], got[9], got[8], got[7:0], ex[10], ex[9], ex[8], ex[7:0]);
      end
    end
  endtask

  task automatic test_basic();
    logic [10:0] got, ex;
    for (int k = 1; k <= 16; k++)
      exp_q.push_back({k <= 12, k <= 15, k == 13, (k <= 12) ? 8'(3 - (k - 1) / 4) : 8'd0});
    for (int k = 1; k <= 16; k++) begin
      trig = (k == 1);
      duration = (k == 1) ? 8'd3 : 8'd7;
      tick();
      trig = 1'b0;
      got = {out, busy, done, remaining}; ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL basic c%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", k,
                 got[10], got[9], got[8], got[7:0], ex[10], ex[9], ex[8], ex[7:0]);
      end
    end
  endtask

  task automatic test_zero_and_cancel();
    logic [10:0] got, ex;
    for (int k = 1; k <= 8; k++) exp_q.push_back(11'd0);
    for (int k = 1; k <= 8; k++) begin
      trig     = (k == 1) || (k == 5);
      cancel   = (k == 5);
      duration = (k == 1) ? 8'd0 : 8'd3;
      tick();
      trig = 1'b0; cancel = 1'b0;
      got = {out, busy, done, remaining}; ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL zero_cancel c%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", k,
                 got[10], got[9], got[8], got[7:0], ex[10], ex[9], ex[8], ex[7:0]);
      end
    end
  endtask

  // Second trigger lands on the edge that begins the 6th high cycle.
  task automatic test_retrigger(input logic rt);
    logic [10:0] got, ex;
    logic [7:0]  r;
    for (int k = 1; k <= 17; k++) begin
      if (rt) begin
        r = (k <= 5) ? 8'(2 - (k - 1) / 4) : (k <= 13) ? 8'(2 - (k - 6) / 4) : 8'd0;
        exp_q.push_back({k <= 13, k <= 16, k == 14, r});
      end else begin
        r = (k <= 8) ? 8'(2 - (k - 1) / 4) : 8'd0;
        exp_q.push_back({k <= 8, k <= 11, k == 9, r});
      end
    end
    retrig = rt;
    duration = 8'd2;
    for (int k = 1; k <= 17; k++) begin
      trig = (k == 1) || (k == 6);
      tick();
      trig = 1'b0;
      got = {out, busy, done, remaining}; ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL retrig%0d c%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", rt, k,
                 got[10], got[9], got[8], got[7:0], ex[10], ex[9], ex[8], ex[7:0]);
      end
    end
    retrig = 1'b0;
  endtask

  // Cancel sampled at the edge ending the 7th high cycle.
  task automatic test_cancel();
    logic [10:0] got, ex;
    for (int k = 1; k <= 12; k++)
      exp_q.push_back({k <= 7, k <= 10, 1'b0, (k <= 7) ? 8'(5 - (k - 1) / 4) : 8'd0});
    duration = 8'd5;
    for (int k = 1; k <= 12; k++) begin
      trig   = (k == 1);
      cancel = (k == 8);
      tick();
      trig = 1'b0; cancel = 1'b0;
      got = {out, busy, done, remaining}; ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL cancel c%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", k,
                 got[10], got[9], got[8], got[7:0], ex[10], ex[9], ex[8], ex[7:0]);
      end
    end
  endtask

  // Triggers on every hold-off cycle are dropped; the one on the first idle cycle starts.
  task automatic test_holdoff();
    logic [10:0] got, ex;
    for (int k = 1; k <= 16; k++) begin
      if (k <= 4 || (k >= 9 && k <= 12)) exp_q.push_back({1'b1, 1'b1, 1'b0, 8'd1});
      else if (k == 5 || k == 13)        exp_q.push_back({1'b0, 1'b1, 1'b1, 8'd0});
      else if (k == 8 || k == 16)        exp_q.push_back(11'd0);
      else                               exp_q.push_back({1'b0, 1'b1, 1'b0, 8'd0});
    end
    duration = 8'd1;
    for (int k = 1; k <= 16; k++) begin
      trig   = (k == 1) || (k >= 6 && k <= 9);
      cancel = (k == 7);
      tick();
      trig = 1'b0; cancel = 1'b0;
      got = {out, busy, done, remaining}; ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL holdoff c%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", k,
                 got[10], got[9], got[8], got[7:0], ex[10], ex[9], ex[8], ex[7:0]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [10:0] got, ex;
    for (int k = 1; k <= 3; k++) exp_q.push_back({1'b1, 1'b1, 1'b0, 8'd3});
    for (int k = 4; k <= 7; k++) exp_q.push_back(11'd0);
    duration = 8'd3;
    for (int k = 1; k <= 7; k++) begin
      if (k == 4) begin
        // Mid-cycle assertion: outputs must clear without waiting for an edge.
        #3;
        rst = 1'b1;
        #1;
      end else begin
        trig = (k == 1);
        tick();
        trig = 1'b0;
      end
      got = {out, busy, done, remaining}; ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL async_rst c%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", k,
                 got[10], got[9], got[8], got[7:0], ex[10], ex[9], ex[8], ex[7:0]);
      end
      if (k == 5) rst = 1'b0;
    end
  endtask

  task automatic test_div1();
    logic [10:0] got, ex;
    exp_q.push_back({1'b1, 1'b1, 1'b0, 8'd1});
    exp_q.push_back({1'b0, 1'b1, 1'b1, 8'd0});
    exp_q.push_back({1'b0, 1'b1, 1'b0, 8'd0});
    exp_q.push_back({1'b0, 1'b1, 1'b0, 8'd0});
    exp_q.push_back(11'd0);
    duration = 8'd1;
    for (int k = 1; k <= 5; k++) begin
      trig = (k == 1);
      tick();
      trig = 1'b0;
      got = {out1, busy1, done1, remaining1}; ex = exp_q.pop_front(); n_vec++;
      if (got !== ex) begin
        n_err++;
        $display("FAIL div1 c%0d: got %b/%b/%b/%0d want %b/%b/%b/%0d", k,
                 got[10], got[9], got[8], got[7:0], ex[10], ex[9], ex[8], ex[7:0]);
      end
    end
  endtask

  initial begin
    rst = 1'b0; trig = 1'b0; cancel = 1'b0; retrig = 1'b0; duration = 8'd0;
    #1;
    test_reset();
    test_basic();
    test_zero_and_cancel();
    test_retrigger(1'b1);
    test_retrigger(1'b0);
    test_cancel();
    test_holdoff();
    test_async_reset();
    test_div1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
